// File: rtl/bcd_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_display_if
// Description : Bus bundle between a BCD source and the multiplexed
//               seven-segment scanner.
//               master : drives bcd_in, load, blank_lz; observes display outputs
//               slave  : the scanner; consumes the BCD word, drives seg,
//                        dig_sel, bcd_err and valid
// Ports       : bcd_in[4*NUM_DIGITS], load, blank_lz  (source -> scanner)
//               seg[7], dig_sel[NUM_DIGITS], bcd_err, valid (scanner -> pins)
// Revision    : 1.0  initial release
// ============================================================================
interface bcd_scan_display_if #(
    parameter int NUM_DIGITS = 3
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    load;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    bcd_err;
    logic                    valid;

    modport master (
        output bcd_in, load, blank_lz,
        input  seg, dig_sel, bcd_err, valid
    );

    modport slave (
        input  bcd_in, load, blank_lz,
        output seg, dig_sel, bcd_err, valid
    );
endinterface
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_display
// Description : Latches a packed BCD word on a load strobe and time-multiplexes
//               its digits onto a shared seven-segment bus with a rotating
//               one-hot digit enable. Optional leading-zero blanking; flags
//               any nibble above 9. All outputs registered.
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               bus      - slave side of bcd_scan_display_if
//                          (bcd_in, load, blank_lz in; seg, dig_sel,
//                           bcd_err, valid out)
// Revision    : 1.0  initial release
// ============================================================================
module bcd_scan_display #(
    parameter int NUM_DIGITS  = 3,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    bcd_scan_display_if.slave bus
);

    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    // XOR masks: inactive level and polarity flip are the same pattern
    localparam logic [6:0]            SEG_POL    = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL    = {NUM_DIGITS{ACTIVE_LOW}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t                  state_q,   state_d;
    logic [4*NUM_DIGITS-1:0] latch_q,   latch_d;
    logic [PRESC_W-1:0]      presc_q,   presc_d;
    logic [IDX_W-1:0]        idx_q,     idx_d;
    logic [6:0]              seg_q,     seg_d;
    logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic                    bcd_err_q, bcd_err_d;
    logic                    valid_q,   valid_d;

    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   dig_onehot;
    logic [6:0]              seg_act;

    // Segment pattern {g,f,e,d,c,b,a}, active-high; non-decimal shows a dash
    function automatic logic [6:0] decode_digit(input logic [3:0] nib);
        case (nib)
            4'd0:    decode_digit = 7'b0111111;
            4'd1:    decode_digit = 7'b0000110;
            4'd2:    decode_digit = 7'b1011011;
            4'd3:    decode_digit = 7'b1001111;
            4'd4:    decode_digit = 7'b1100110;
            4'd5:    decode_digit = 7'b1101101;
            4'd6:    decode_digit = 7'b1111101;
            4'd7:    decode_digit = 7'b0000111;
            4'd8:    decode_digit = 7'b1111111;
            4'd9:    decode_digit = 7'b1101111;
            default: decode_digit = 7'b1000000;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        latch_d    = bus.load ? bus.bcd_in : latch_q;
        presc_d    = presc_q;
        idx_d      = idx_q;
        cur_nib    = 4'd0;
        cur_blank  = 1'b0;
        dig_onehot = '0;
        lz_run     = bus.blank_lz;
        bcd_err_d  = 1'b0;

        if (state_q == ST_IDLE && bus.load) begin
            state_d = ST_SCAN;
        end

        // Prescaler and index only run once scanning; loads never touch them
        if (state_q == ST_SCAN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        // Walk from the most significant digit down: lz_run stays high only
        // while this nibble and every nibble above it are zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run && (latch_q[4*i +: 4] == 4'd0);
            if (latch_q[4*i +: 4] > 4'd9) begin
                bcd_err_d = 1'b1;
            end
            if (idx_q == IDX_W'(i)) begin
                cur_nib       = latch_q[4*i +: 4];
                cur_blank     = lz_run && (i != 0);
                dig_onehot[i] = 1'b1;
            end
        end

        seg_act = cur_blank ? 7'd0 : decode_digit(cur_nib);

        if (state_q == ST_SCAN) begin
            seg_d     = seg_act ^ SEG_POL;
            dig_sel_d = dig_onehot ^ DIG_POL;
            valid_d   = 1'b1;
        end else begin
            seg_d     = SEG_POL;
            dig_sel_d = DIG_POL;
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            latch_q   <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_POL;
            dig_sel_q <= DIG_POL;
            bcd_err_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            latch_q   <= latch_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
            bcd_err_q <= bcd_err_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dig_sel = dig_sel_q;
    assign bus.bcd_err = bcd_err_q;
    assign bus.valid   = valid_q;

endmodule
`default_nettype wire

// File: doc/bcd_scan_display.md
# bcd_scan_display

Downstream consumer of the binary-to-BCD converter's 12-bit packed BCD output. Latches a BCD word on a load strobe and time-multiplexes its digits onto one shared seven-segment bus with a rotating one-hot digit enable. Provides optional leading-zero blanking and flags non-decimal nibbles. Sits between the converter and the board's display pins.

## Interface
- NUM_DIGITS, 3, number of BCD digits scanned; bcd_in width is 4*NUM_DIGITS
- REFRESH_DIV, 50000, clock cycles each digit stays enabled; legal range ≥2
- ACTIVE_LOW, 1, when 1 both seg and dig_sel are driven active-low; when 0 both are active-high

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- bcd_in  in  4*NUM_DIGITS  packed BCD; nibble i = digit i; digit 0 is least significant (bits 3:0)
- load  in  1  when high at a rising edge, bcd_in is captured; may be held high (recaptures every cycle)
- blank_lz  in  1  enables leading-zero blanking; sampled each cycle, not latched
- seg  out  7  segment pattern {g,f,e,d,c,b,a} for the currently enabled digit
- dig_sel  out  NUM_DIGITS  one-hot digit enable
- bcd_err  out  1  high while the latched word contains any nibble >9
- valid  out  1  high once at least one load has been captured since reset

## Operation
- Two states:
  - IDLE (after reset): seg and dig_sel are all inactive.
  - SCAN: entered on the first edge with load=1. The block never returns to IDLE except through reset.
- Latch register: captured on every edge with load=1. Cleared to 0 on reset.
- Prescaler: counts 0..REFRESH_DIV-1 in SCAN and holds at 0 in IDLE. At the terminal count, the digit index advances 0→1→…→NUM_DIGITS-1→0, and the prescaler wraps to 0.
- Digit index reset value: 0. The first digit enabled in SCAN is digit 0.
- A load does not reset the prescaler or the index, so scanning cadence is independent of loads.
- Decoding, active-high internally before polarity is applied:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Any nibble 10–15 displays a dash (1000000).
- Leading-zero blanking:
  - Digit i (i≠0) is blanked (seg all inactive) when blank_lz=1 and every latched nibble from i through NUM_DIGITS-1 equals 0.
  - Digit 0 is never blanked.
  - dig_sel still rotates onto blanked digits.
- bcd_err is combinational on the latched word and registered with the outputs.
- When ACTIVE_LOW=1, the final seg and dig_sel values are inverted.

## Timing
- All outputs are registered.
- Reset values:
  - seg = all inactive: 7'h7F if ACTIVE_LOW, else 0.
  - dig_sel = all inactive.
  - bcd_err = 0, valid = 0.
- Latency:
  - A load captured at edge N is reflected on seg, bcd_err and valid at edge N+1.
  - dig_sel becomes active for digit 0 at edge N+1 after the first load.
  - A mid-slot load changes seg at N+1 without disturbing dig_sel.
- Digit period: dig_sel changes exactly every REFRESH_DIV cycles. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- seg and dig_sel update on the same edge, so there is never a cycle in which a new digit is enabled with the previous digit's pattern.
- Changing blank_lz takes effect at the next edge.
- Reset asserted mid-scan: all outputs go to reset values immediately (asynchronously). The block returns to IDLE and the latch clears. After release, nothing is displayed until the next load.
- load held high continuously: value tracks bcd_in with 1-cycle latency; scanning is unaffected.

## Test plan
Parameters for all scenarios: NUM_DIGITS=3, REFRESH_DIV=4, ACTIVE_LOW=1.
- **Reset/idle:** rst_n low, then release with no load for 20 cycles → seg=7'h7F, dig_sel=3'b111, valid=0, bcd_err=0 throughout.
- **Load and scan:** load bcd_in=12'h015 with blank_lz=0 → next edge dig_sel=3'b110 and seg=~7'b1101101 (5). After 4 cycles dig_sel=3'b101 and seg=~7'b0000110 (1). After 4 more, dig_sel=3'b011 and seg=~7'b0111111 (0). After 4 more, wraps back to 3'b110.
- **Leading-zero blanking:** load 12'h007 with blank_lz=1 → digit 0 shows ~7'b0000111; digits 1 and 2 show seg=7'h7F while their dig_sel bit is low. Load 12'h000 → digits 1 and 2 blank and digit 0 shows 0.
- **Invalid nibble:** load 12'h0A3 → digit 1 shows ~7'b1000000 and bcd_err=1 one cycle after load. Then load 12'h013 → bcd_err=0 on the next edge.
- **Mid-slot reload:** load 12'h001, wait 2 cycles into the digit-0 slot, then load 12'h009 → seg changes to 9 on the next edge. dig_sel still changes exactly 4 cycles after its previous change.
- **Reset mid-operation:** during a scan, pulse rst_n low for 1 cycle → outputs go inactive immediately and valid=0. After release, outputs stay inactive until load; the first scan after load starts at digit 0.
